// File: rtl/h2c_stream_unpack.sv
// H2C receive path: reassembles fixed-size AXI-Stream packets into one wide word
// and hands it to the DUT wrapper over a valid/ready handshake.
module h2c_stream_unpack #(
  parameter int AXIS_WIDTH = 512,
  parameter int OUT_WIDTH  = 4064,
  parameter int BEATS      = 8
) (
  input  logic                    xdma_clk,
  input  logic                    xdma_resetn,
  input  logic [AXIS_WIDTH-1:0]   s_axis_h2c_tdata,
  input  logic [AXIS_WIDTH/8-1:0] s_axis_h2c_tkeep,
  input  logic                    s_axis_h2c_tlast,
  input  logic                    s_axis_h2c_tvalid,
  output logic                    s_axis_h2c_tready,
  output logic [OUT_WIDTH-1:0]    out_io_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_short,
  output logic                    err_long,
  output logic [31:0]             pkt_count,
  output logic [15:0]             drop_count
);

  localparam int BUF_WIDTH = BEATS * AXIS_WIDTH;
  localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     beat_idx, beat_idx_next;
  logic [BUF_WIDTH-1:0] asm_buf;
  logic [BUF_WIDTH-1:0] asm_word;
  logic                 at_last;
  logic                 final_stall;
  logic                 buf_we;
  logic                 do_load;
  logic                 do_short;
  logic                 do_long;
  logic                 unused_bits;

  assign at_last = (beat_idx == LAST_IDX);

  // Only the final beat waits for the consumer; earlier beats land in the
  // buffer while the previous word is still held in the output register.
  assign final_stall = at_last && out_valid && !out_ready;

  // The final beat bypasses the buffer so the word can load on its handshake.
  always_comb begin
    asm_word = asm_buf;
    asm_word[(BEATS-1)*AXIS_WIDTH +: AXIS_WIDTH] = s_axis_h2c_tdata;
  end

  // tkeep is deliberately ignored and bits above OUT_WIDTH are discarded.
  assign unused_bits = ^{s_axis_h2c_tkeep, asm_word};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next        = state;
    beat_idx_next     = beat_idx;
    s_axis_h2c_tready = 1'b1;
    buf_we            = 1'b0;
    do_load           = 1'b0;
    do_short          = 1'b0;
    do_long           = 1'b0;
    case (state)
      COLLECT: begin
        s_axis_h2c_tready = !final_stall;
        if (s_axis_h2c_tvalid && !final_stall) begin
          buf_we = 1'b1;
          if (!at_last) begin
            if (s_axis_h2c_tlast) begin
              do_short      = 1'b1;
              beat_idx_next = '0;
            end else begin
              beat_idx_next = beat_idx + IDX_W'(1);
            end
          end else begin
            beat_idx_next = '0;
            if (s_axis_h2c_tlast) begin
              do_load = 1'b1;
            end else begin
              do_long    = 1'b1;
              state_next = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (s_axis_h2c_tvalid && s_axis_h2c_tlast) begin
          state_next    = COLLECT;
          beat_idx_next = '0;
        end
      end
      default: begin
        state_next    = COLLECT;
        beat_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      state    <= COLLECT;
      beat_idx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_next;
      beat_idx <= beat_idx_next;
    end
  end

  // NOTE: the assembly buffer is plain flops, not a RAM, so it can and does take the reset value.
  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      asm_buf <= '0;
    end else if (buf_we) begin
      asm_buf[int'(beat_idx)*AXIS_WIDTH +: AXIS_WIDTH] <= s_axis_h2c_tdata;
    end
  end

  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      out_io_data <= '0;
      out_valid   <= 1'b0;
      pkt_count   <= '0;
    end else begin
      if (do_load) begin
        out_io_data <= asm_word[OUT_WIDTH-1:0];
        out_valid   <= 1'b1;
        pkt_count   <= pkt_count + 32'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
    if (!xdma_resetn) begin
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      drop_count <= '0;
    end else begin
      err_short <= do_short;
      err_long  <= do_long;
      if ((do_short || do_long) && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_h2c_stream_unpack.sv
// Directed bench for h2c_stream_unpack: table of packet shapes plus hand-written
// sequences for backpressure, bubbles, counter saturation and mid-packet reset.
`timescale 1ns/1ps
module tb_h2c_stream_unpack;

  localparam int AW = 512;
  localparam int OW = 4064;
  localparam int NB = 8;

  logic          xdma_clk = 1'b0;
  logic          xdma_resetn;
  logic [AW-1:0] s_axis_h2c_tdata;
  logic [AW/8-1:0] s_axis_h2c_tkeep;
  logic          s_axis_h2c_tlast;
  logic          s_axis_h2c_tvalid;
  logic          s_axis_h2c_tready;
  logic [OW-1:0] out_io_data;
  logic          out_valid;
  logic          out_ready;
  logic          err_short;
  logic          err_long;
  logic [31:0]   pkt_count;
  logic [15:0]   drop_count;

  h2c_stream_unpack #(.AXIS_WIDTH(AW), .OUT_WIDTH(OW), .BEATS(NB)) dut (
    .xdma_clk          (xdma_clk),
    .xdma_resetn       (xdma_resetn),
    .s_axis_h2c_tdata  (s_axis_h2c_tdata),
    .s_axis_h2c_tkeep  (s_axis_h2c_tkeep),
    .s_axis_h2c_tlast  (s_axis_h2c_tlast),
    .s_axis_h2c_tvalid (s_axis_h2c_tvalid),
    .s_axis_h2c_tready (s_axis_h2c_tready),
    .out_io_data       (out_io_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .err_short         (err_short),
    .err_long          (err_long),
    .pkt_count         (pkt_count),
    .drop_count        (drop_count)
  );

  always #5 xdma_clk = ~xdma_clk;

  typedef struct {
    int         n_beats;
    int         last_at;
    logic [7:0] base;
    bit         exp_deliver;
    bit         exp_short;
    bit         exp_long;
  } vec_t;

  vec_t vecs[9];

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_pkt;
  int          exp_drop;

  task automatic check(input string name, input logic [4095:0] act, input logic [4095:0] exp);
    int c;
    n_cmp++;
    if (act !== exp) begin
      c = 0;
      for (int i = 63; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
      n_fail++;
      $display("FAIL %s: chunk %0d got %h want %h", name, c, act[c*64 +: 64], exp[c*64 +: 64]);
    end
  endtask

  function automatic logic [AW-1:0] beat_pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic logic [OW-1:0] build_word(input logic [7:0] base);
    logic [NB*AW-1:0] t;
    for (int k = 0; k < NB; k++) t[k*AW +: AW] = beat_pat(base + 8'(k));
    return t[OW-1:0];
  endfunction

  // Presents one beat from a falling edge and returns on the falling edge
  // after the handshake, with tvalid still high.
  task automatic send_beat(input logic [AW-1:0] d, input logic last);
    int n;
    s_axis_h2c_tdata  = d;
    s_axis_h2c_tlast  = last;
    s_axis_h2c_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axis_h2c_tready && n < 200) begin
      @(negedge xdma_clk);
      #1;
      n++;
    end
    if (!s_axis_h2c_tready) check("tready_wait", s_axis_h2c_tready, 1);
    @(posedge xdma_clk);
    @(negedge xdma_clk);
  endtask

  task automatic idle(input int n);
    s_axis_h2c_tvalid = 1'b0;
    s_axis_h2c_tlast  = 1'b0;
    repeat (n) @(negedge xdma_clk);
  endtask

  task automatic bump_drop();
    if (exp_drop < 16'hFFFF) exp_drop++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s_now, l_now, d_now;
    logic [7:0] b;

    vecs[0] = '{8,  7,  8'h01, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4,  3,  8'h20, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8,  7,  8'h30, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{11, 10, 8'h40, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8,  7,  8'h50, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1,  0,  8'h60, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8,  7,  8'h70, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{7,  6,  8'h80, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8,  7,  8'h90, 1'b1, 1'b0, 1'b0};

    xdma_resetn       = 1'b0;
    s_axis_h2c_tdata  = '0;
    s_axis_h2c_tkeep  = '1;
    s_axis_h2c_tlast  = 1'b0;
    s_axis_h2c_tvalid = 1'b0;
    out_ready         = 1'b1;
    exp_pkt           = 0;
    exp_drop          = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_io_data, 0);
    check("rst_pkt", pkt_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_errs", {err_short, err_long}, 0);
    check("rst_tready", s_axis_h2c_tready, 1);
    repeat (2) @(negedge xdma_clk);
    xdma_resetn = 1'b1;
    @(negedge xdma_clk);

    // Packet shapes with out_ready held high.
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < vecs[v].n_beats; k++) begin
        b = vecs[v].base + 8'(k);
        send_beat(beat_pat(b), k == vecs[v].last_at);
        s_now = vecs[v].exp_short   && (k == vecs[v].last_at);
        l_now = vecs[v].exp_long    && (k == NB - 1);
        d_now = vecs[v].exp_deliver && (k == NB - 1);
        check($sformatf("v%0d_b%0d_err_short", v, k), err_short, s_now);
        check($sformatf("v%0d_b%0d_err_long", v, k), err_long, l_now);
        check($sformatf("v%0d_b%0d_out_valid", v, k), out_valid, d_now);
        if (d_now) check($sformatf("v%0d_word", v), out_io_data, build_word(vecs[v].base));
      end
      if (vecs[v].exp_deliver) exp_pkt++;
      if (vecs[v].exp_short || vecs[v].exp_long) bump_drop();
      idle(1);
      check($sformatf("v%0d_pkt_count", v), pkt_count, exp_pkt);
      check($sformatf("v%0d_drop_count", v), drop_count, exp_drop);
      check($sformatf("v%0d_idle_valid", v), out_valid, 0);
      check($sformatf("v%0d_idle_errs", v), {err_short, err_long}, 0);
    end

    // Backpressure: word A held while packet B fills beats 0..6, then B's final beat stalls.
    out_ready = 1'b0;
    for (int k = 0; k < NB; k++) send_beat(beat_pat(8'hA0 + 8'(k)), k == NB - 1);
    exp_pkt++;
    check("bp_a_valid", out_valid, 1);
    check("bp_a_word", out_io_data, build_word(8'hA0));
    check("bp_a_pkt", pkt_count, exp_pkt);
    for (int k = 0; k < NB - 1; k++) begin
      send_beat(beat_pat(8'hB0 + 8'(k)), 1'b0);
      check($sformatf("bp_hold_b%0d", k), out_io_data, build_word(8'hA0));
    end
    s_axis_h2c_tdata  = beat_pat(8'hB7);
    s_axis_h2c_tlast  = 1'b1;
    s_axis_h2c_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_stall_tready%0d", i), s_axis_h2c_tready, 0);
      check($sformatf("bp_stall_word%0d", i), out_io_data, build_word(8'hA0));
      check($sformatf("bp_stall_valid%0d", i), out_valid, 1);
      @(negedge xdma_clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_tready", s_axis_h2c_tready, 1);
    @(posedge xdma_clk);
    @(negedge xdma_clk);
    exp_pkt++;
    out_ready = 1'b0;
    check("bp_b_valid", out_valid, 1);
    check("bp_b_word", out_io_data, build_word(8'hB0));
    check("bp_b_pkt", pkt_count, exp_pkt);
    idle(2);
    check("bp_b_hold_valid", out_valid, 1);
    check("bp_b_hold_word", out_io_data, build_word(8'hB0));
    out_ready = 1'b1;
    @(negedge xdma_clk);
    check("bp_drained", out_valid, 0);

    // Bubbles: random idle gaps with junk on the bus.
    for (int k = 0; k < NB; k++) begin
      s_axis_h2c_tvalid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        s_axis_h2c_tdata = {16{$urandom()}};
        s_axis_h2c_tlast = 1'($urandom_range(0, 1));
        @(negedge xdma_clk);
        check($sformatf("bub_gap_b%0d", k), {out_valid, err_short, err_long}, 0);
      end
      send_beat(beat_pat(8'hE0 + 8'(k)), k == NB - 1);
    end
    exp_pkt++;
    check("bub_valid", out_valid, 1);
    check("bub_word", out_io_data, build_word(8'hE0));
    check("bub_pkt", pkt_count, exp_pkt);
    idle(1);

    // Saturation: 65537 one-beat short packets back to back.
    for (int i = 0; i < 65537; i++) begin
      send_beat(beat_pat(8'hF0), 1'b1);
      bump_drop();
    end
    check("sat_err_short", err_short, 1);
    idle(1);
    check("sat_drop", drop_count, exp_drop);
    check("sat_drop_max", drop_count, 16'hFFFF);
    check("sat_pkt", pkt_count, exp_pkt);
    check("sat_valid", out_valid, 0);
    send_beat(beat_pat(8'hF1), 1'b1);
    check("sat_err_again", err_short, 1);
    idle(1);
    check("sat_hold", drop_count, 16'hFFFF);

    // Reset mid-packet with a held word and non-zero counters.
    out_ready = 1'b0;
    for (int k = 0; k < NB; k++) send_beat(beat_pat(8'hC0 + 8'(k)), k == NB - 1);
    for (int k = 0; k < 5; k++) send_beat(beat_pat(8'hC8 + 8'(k)), 1'b0);
    s_axis_h2c_tvalid = 1'b0;
    #2;
    xdma_resetn = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_word", out_io_data, 0);
    check("mrst_pkt", pkt_count, 0);
    check("mrst_drop", drop_count, 0);
    check("mrst_errs", {err_short, err_long}, 0);
    check("mrst_tready", s_axis_h2c_tready, 1);
    @(negedge xdma_clk);
    xdma_resetn = 1'b1;
    out_ready   = 1'b1;
    exp_pkt     = 0;
    exp_drop    = 0;
    @(negedge xdma_clk);
    for (int k = 0; k < NB; k++) send_beat(beat_pat(8'hD0 + 8'(k)), k == NB - 1);
    exp_pkt++;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_word", out_io_data, build_word(8'hD0));
    check("post_rst_pkt", pkt_count, exp_pkt);
    check("post_rst_drop", drop_count, exp_drop);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
